// File: rtl/barvinn_sim_monitor.sv
// BARVINN run controller / watchdog for simulation and FPGA bring-up.
// Tracks NUM_CH channels (done, pass, activity) and ends the run on completion,
// per-channel hang or global cycle timeout.
// Optional feature macro: BARVINN_SIM_MON_STAMP_EN (adds per-channel ch_stamp).

// Per-channel tracker: sticky done/pass/hang plus saturating idle counter.
module barvinn_sim_monitor_ch #(
  parameter int HANG_W      = 16,
  parameter int HANG_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  input  logic en,
  input  logic done_in,
  input  logic pass_in,
  input  logic act,
  output logic done_nx,
  output logic hang_nx,
  output logic done,
  output logic pass_q,
  output logic hang
);
  localparam logic [HANG_W-1:0] HLIM  = HANG_W'(HANG_CYCLES);
  localparam logic [HANG_W-1:0] HLAST = HANG_W'(HANG_CYCLES - 1);

  logic [HANG_W-1:0] idle;
  logic              first;
  logic              hit;

  // Next-cycle view of the sticky flags, so the run controller can terminate
  // in the same cycle the event arrives.
  always_comb begin
    first   = run & en & done_in & ~done;
    done_nx = done | (run & en & done_in);
    hit     = run & en & ~done_nx & ~act & (idle == HLAST);
    hang_nx = hang | hit;
  end

  // Flag and idle-counter state; frozen outside RUN, cleared on a new run.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      done   <= 1'b0;
      pass_q <= 1'b0;
      hang   <= 1'b0;
      idle   <= '0;
    end else if (run) begin
      done <= done_nx;
      hang <= hang_nx;
      if (first) pass_q <= pass_in;
      if (act || done_nx)           idle <= '0;
      else if (en && idle != HLIM)  idle <= idle + 1'b1;
    end
  end
endmodule

// Top: run FSM, global cycle counter and per-channel tracker array.
module barvinn_sim_monitor #(
  parameter int NUM_CH         = 8,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int HANG_W         = 16,
  parameter int HANG_CYCLES    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_done,
  input  logic [NUM_CH-1:0] ch_pass,
  input  logic [NUM_CH-1:0] ch_activity,
  output logic              busy,
  output logic              finished,
  output logic              pass,
  output logic              timeout,
  output logic [NUM_CH-1:0] hang_mask,
  output logic [NUM_CH-1:0] done_mask,
  output logic [CNT_W-1:0]  cycle_cnt
`ifdef BARVINN_SIM_MON_STAMP_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] ch_stamp
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ABORT} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              run, start_acc, all_done, any_hang, to_hit;
  logic [NUM_CH-1:0] en_q, done_nx, hang_nx, pass_q;

  assign run       = (state_q == S_RUN);
  assign start_acc = start & ~run;
  assign all_done  = &(done_nx | ~en_q);
  assign any_hang  = |hang_nx;
  assign to_hit    = (cycle_cnt == TO_LAST);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      barvinn_sim_monitor_ch #(
        .HANG_W     (HANG_W),
        .HANG_CYCLES(HANG_CYCLES)
      ) u_ch (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_acc),
        .run    (run),
        .en     (en_q[g]),
        .done_in(ch_done[g]),
        .pass_in(ch_pass[g]),
        .act    (ch_activity[g]),
        .done_nx(done_nx[g]),
        .hang_nx(hang_nx[g]),
        .done   (done_mask[g]),
        .pass_q (pass_q[g]),
        .hang   (hang_mask[g])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: completion beats hang, hang beats timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (all_done)      state_d = S_DONE;
        else if (any_hang) state_d = S_ABORT;
        else if (to_hit)   state_d = S_ABORT;
      end
      S_DONE, S_ABORT: if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Run bookkeeping: enable mask, cycle counter, timeout cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= '0;
      cycle_cnt <= '0;
      timeout   <= 1'b0;
    end else if (start_acc) begin
      en_q      <= ch_en;
      cycle_cnt <= '0;
      timeout   <= 1'b0;
    end else if (run) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      timeout   <= ~all_done & ~any_hang & to_hit;
    end
  end

  assign busy     = run;
  assign finished = (state_q == S_DONE) || (state_q == S_ABORT);
  assign pass     = (state_q == S_DONE) && (&(pass_q | ~en_q));

`ifdef BARVINN_SIM_MON_STAMP_EN
  logic [NUM_CH-1:0][CNT_W-1:0] stamp_q;

  // Capture cycle_cnt at each channel's first done.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stamp_q <= '0;
    end else if (run) begin
      for (int i = 0; i < NUM_CH; i++)
        if (en_q[i] && ch_done[i] && !done_mask[i]) stamp_q[i] <= cycle_cnt;
    end
  end

  assign ch_stamp = stamp_q;
`endif
endmodule

// File: tb/tb_barvinn_sim_monitor.sv
// Scoreboard bench for barvinn_sim_monitor (NUM_CH=4, TIMEOUT=100, HANG=16).
module tb_barvinn_sim_monitor;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [NC-1:0] ch_en, ch_done, ch_pass, ch_activity;
  logic          busy, finished, pass, timeout;
  logic [NC-1:0] hang_mask, done_mask;
  logic [31:0]   cycle_cnt;
`ifdef BARVINN_SIM_MON_STAMP_EN
  logic [NC*32-1:0] ch_stamp;
`endif

  barvinn_sim_monitor #(
    .NUM_CH(NC), .CNT_W(32), .TIMEOUT_CYCLES(100), .HANG_W(16), .HANG_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ch_en(ch_en), .ch_done(ch_done),
    .ch_pass(ch_pass), .ch_activity(ch_activity), .busy(busy), .finished(finished),
    .pass(pass), .timeout(timeout), .hang_mask(hang_mask), .done_mask(done_mask),
    .cycle_cnt(cycle_cnt)
`ifdef BARVINN_SIM_MON_STAMP_EN
    , .ch_stamp(ch_stamp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string     tag;
    logic      pass;
    logic      tmo;
    logic [3:0] hang;
    logic [3:0] done;
    logic [31:0] cnt;
    logic      chk_hang;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Per-case stimulus: done_at = cycle_cnt value during which done pulses,
  // act_stop = last cycle_cnt with activity (heartbeat every 8 cycles up to it).
  int         done_at [NC];
  int         act_stop[NC];
  logic [3:0] pv;
  int         start_at;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic drive(input int k);
    for (int i = 0; i < NC; i++) begin
      ch_done[i]     = (k == done_at[i]);
      ch_pass[i]     = pv[i];
      ch_activity[i] = (k <= act_stop[i]) && ((k % 8 == 0) || (k == act_stop[i]));
    end
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fin"},  finished, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_tmo"},  timeout, 0);
    chk({tag, "_hang"}, hang_mask, 0);
    chk({tag, "_done"}, done_mask, 0);
    chk({tag, "_cnt"},  cycle_cnt, 0);
  endtask

  task automatic run_case(input string tag, input logic [3:0] en, input logic pe,
                          input logic te, input logic [3:0] he, input logic [3:0] de,
                          input int ce, input logic chh, input int rst_at);
    exp_t e;
    bit   fin = 0;
    if (rst_at < 0) begin
      e.tag = tag; e.pass = pe; e.tmo = te; e.hang = he; e.done = de;
      e.cnt = ce; e.chk_hang = chh;
      exp_q.push_back(e);
    end
    @(negedge clk); start = 1'b1; ch_en = en;
    @(negedge clk); start = 1'b0; ch_en = '0;
    chk({tag, "_st_busy"}, busy, 1);
    chk({tag, "_st_fin"},  finished, 0);
    chk({tag, "_st_cnt"},  cycle_cnt, 0);
    chk({tag, "_st_hang"}, hang_mask, 0);
    for (int k = 0; k < 300 && !fin; k++) begin
      drive(k);
      start = (k == start_at);
      if (k == rst_at) rst = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (k == rst_at) begin
        idle_outputs({tag, "_rst"});
        rst = 1'b0;
        fin = 1;
      end else if (finished) begin
        fin = 1;
      end
    end
    ch_done = '0; ch_activity = '0; ch_pass = '0;
    if (rst_at < 0) begin
      e = exp_q.pop_front();
      if (!fin) begin
        chk({e.tag, "_no_finish"}, 0, 1);
      end else begin
        chk({e.tag, "_busy"}, busy, 0);
        chk({e.tag, "_pass"}, pass, e.pass);
        chk({e.tag, "_tmo"},  timeout, e.tmo);
        chk({e.tag, "_done"}, done_mask, e.done);
        chk({e.tag, "_cnt"},  cycle_cnt, e.cnt);
        if (e.chk_hang) chk({e.tag, "_hang"}, hang_mask, e.hang);
      end
    end
  endtask

  task automatic set_all(input int d0, d1, d2, d3, input int a0, a1, a2, a3,
                         input logic [3:0] p, input int s);
    done_at[0] = d0; done_at[1] = d1; done_at[2] = d2; done_at[3] = d3;
    act_stop[0] = a0; act_stop[1] = a1; act_stop[2] = a2; act_stop[3] = a3;
    pv = p; start_at = s;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ch_en = '0; ch_done = '0; ch_pass = '0; ch_activity = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    idle_outputs("reset");

    // All four channels complete at RUN cycles 10,20,30,40 and pass.
    set_all(9, 19, 29, 39, 1000, 1000, 1000, 1000, 4'b1111, -1);
    run_case("complete", 4'b1111, 1, 0, 4'b0000, 4'b1111, 40, 1, -1);

    // Channel 2 reports fail.
    set_all(9, 19, 29, 39, 1000, 1000, 1000, 1000, 4'b1011, -1);
    run_case("ch2_fail", 4'b1111, 0, 0, 4'b0000, 4'b1111, 40, 1, -1);

    // Channel 1 silent: hang after 16 idle cycles.
    set_all(-1, -1, -1, -1, 1000, -1, 1000, 1000, 4'b1111, -1);
    run_case("hang", 4'b1111, 0, 0, 4'b0010, 4'b0000, 16, 1, -1);

    // Restart after ABORT (hang_mask cleared at start), then global timeout.
    set_all(-1, -1, -1, -1, 1000, 1000, 1000, 1000, 4'b1111, -1);
    run_case("timeout", 4'b1111, 0, 1, 4'b0000, 4'b0000, 100, 1, -1);

    // Last done, idle limit and timeout all land on cycle_cnt 99.
    set_all(9, 19, 29, 99, 1000, 1000, 1000, 83, 4'b1111, -1);
    run_case("simul", 4'b1111, 1, 0, 4'b0000, 4'b1111, 100, 0, -1);

    // No channels enabled: vacuous completion.
    set_all(-1, -1, -1, -1, 1000, 1000, 1000, 1000, 4'b0000, -1);
    run_case("vacuous", 4'b0000, 1, 0, 4'b0000, 4'b0000, 1, 1, -1);

    // Partial enable: channel 3 disabled and never done.
    set_all(4, 7, 12, -1, 1000, 1000, 1000, -1, 4'b0111, -1);
    run_case("partial", 4'b0111, 1, 0, 4'b0000, 4'b0111, 13, 1, -1);

    // Start pulse mid-run must be ignored.
    set_all(9, 19, 29, 39, 1000, 1000, 1000, 1000, 4'b1111, 20);
    run_case("start_in_run", 4'b1111, 1, 0, 4'b0000, 4'b1111, 40, 1, -1);

    // Reset mid-run returns everything to zero.
    set_all(5, -1, -1, -1, 1000, 1000, 1000, 1000, 4'b1111, -1);
    run_case("rst_mid", 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 0, 30);

    // Clean run after the reset.
    set_all(9, 19, 29, 39, 1000, 1000, 1000, 1000, 4'b1111, -1);
    run_case("after_rst", 4'b1111, 1, 0, 4'b0000, 4'b1111, 40, 1, -1);

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
